// File: rtl/cjb_nbit_alu_seq_if.sv
// cjb_nbit_alu_seq_if: request/result bundle between the cjbRISC read stage and the sequential ALU.
interface cjb_nbit_alu_seq_if #(parameter int WIDTH = 8);
  logic             Start;
  logic [3:0]       Func_Sel;
  logic [WIDTH-1:0] Operand_X;
  logic [WIDTH-1:0] Operand_Y;
  logic [1:0]       Const_K;
  logic             cin;
  logic [WIDTH-1:0] ALU_Result;
  logic [3:0]       ALU_CNVZ;
  logic             Busy;
  logic             Done;
  modport master (output Start, Func_Sel, Operand_X, Operand_Y, Const_K, cin,
                  input  ALU_Result, ALU_CNVZ, Busy, Done);
  modport slave  (input  Start, Func_Sel, Operand_X, Operand_Y, Const_K, cin,
                  output ALU_Result, ALU_CNVZ, Busy, Done);
endinterface

// File: rtl/cjb_nbit_alu_seq.sv
// cjb_nbit_alu_seq: registered WIDTH-bit ALU with Start/Busy/Done handshake and a bit-serial shifter.
// Defining CJB_ALU_BARREL_EN swaps the bit-serial shifter for a single-cycle barrel shifter.
module cjb_nbit_alu_seq #(parameter int WIDTH = 8) (
  input logic               Clock,
  input logic               Resetn,
  cjb_nbit_alu_seq_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, res_q;
  logic [SH_W-1:0]  cnt_q;
  logic [1:0]       op_q;
  logic             c_q, done_q;
  logic [3:0]       cnvz_q;
  logic [WIDTH-1:0] x, y, k, b, lg, cn, imm_r, sh_r, step_sh;
  logic [WIDTH:0]   sum;
  logic [1:0]       grp, op;
  logic [SH_W-1:0]  n;
  logic             cin, ci, imm_c, imm_v, sh_c, step_c, go_shift;
  assign x = bus.Operand_X;
  assign y = bus.Operand_Y;
  assign cin = bus.cin;
  assign grp = bus.Func_Sel[3:2];
  assign op = bus.Func_Sel[1:0];
  assign n = bus.Operand_Y[SH_W-1:0];
  assign k = {{(WIDTH-2){1'b0}}, bus.Const_K};
  always_comb begin
    b = op == 2'b10 ? ~y : op == 2'b11 ? k : y;
    ci = op == 2'b01 ? cin : op == 2'b10;
    sum = {1'b0, x} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    lg = op == 2'b00 ? x & y : op == 2'b01 ? x | y : op == 2'b10 ? x ^ y : ~x;
    cn = op == 2'b00 ? '0 : op == 2'b01 ? {{(WIDTH-1){1'b0}}, 1'b1} : op == 2'b10 ? '1 : k;
    imm_r = grp == 2'b00 ? sum[WIDTH-1:0] : grp == 2'b01 ? lg : grp == 2'b10 ? sh_r : cn;
    imm_c = grp == 2'b00 ? sum[WIDTH] : grp == 2'b10 ? sh_c : 1'b0;
    imm_v = grp == 2'b00 && x[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != x[WIDTH-1];
  end
`ifdef CJB_ALU_BARREL_EN
  logic [WIDTH:0] lsl_v, lsr_v, asr_v, rol_v;
  always_comb begin
    lsl_v = {1'b0, x} << n;
    lsr_v = {x, 1'b0} >> n;
    asr_v = $signed({x, 1'b0}) >>> n;
    rol_v = ({cin, x} << n) | ({cin, x} >> ((WIDTH + 1) - int'(n)));
    sh_r = op == 2'b00 ? lsl_v[WIDTH-1:0] : op == 2'b01 ? lsr_v[WIDTH:1] : op == 2'b10 ? asr_v[WIDTH:1] : rol_v[WIDTH-1:0];
    sh_c = op == 2'b00 ? lsl_v[WIDTH] : op == 2'b01 ? lsr_v[0] : op == 2'b10 ? asr_v[0] : rol_v[WIDTH];
  end
  assign go_shift = 1'b0;
`else
  // A zero shift amount finishes immediately; only ROLC reports a nonzero carry then.
  assign sh_r = x;
  assign sh_c = op == 2'b11 && cin;
  assign go_shift = grp == 2'b10 && n != '0;
`endif
  // ROLC treats {c_q, sh_q} as one WIDTH+1 bit ring.
  always_comb begin
    step_c = op_q == 2'b00 || op_q == 2'b11 ? sh_q[WIDTH-1] : sh_q[0];
    step_sh = op_q == 2'b00 ? {sh_q[WIDTH-2:0], 1'b0} :
              op_q == 2'b01 ? {1'b0, sh_q[WIDTH-1:1]} :
              op_q == 2'b10 ? {sh_q[WIDTH-1], sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], c_q};
    state_d = state_q == IDLE ? (bus.Start && go_shift ? SHIFT : IDLE) :
              (cnt_q == SH_W'(1) ? IDLE : SHIFT);
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      c_q <= 1'b0;
      res_q <= '0;
      cnvz_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= 1'b0;
      if (state_q == IDLE && bus.Start) begin
        if (go_shift) begin
          sh_q <= x;
          cnt_q <= n;
          op_q <= op;
          c_q <= op == 2'b11 && cin;
        end else begin
          res_q <= imm_r;
          cnvz_q <= {imm_c, imm_r[WIDTH-1], imm_v, imm_r == '0};
          done_q <= 1'b1;
        end
      end else if (state_q == SHIFT) begin
        sh_q <= step_sh;
        c_q <= step_c;
        cnt_q <= cnt_q - SH_W'(1);
        if (cnt_q == SH_W'(1)) begin
          res_q <= step_sh;
          cnvz_q <= {step_c, step_sh[WIDTH-1], 1'b0, step_sh == '0};
          done_q <= 1'b1;
        end
      end
    end
  end
  assign bus.ALU_Result = res_q;
  assign bus.ALU_CNVZ = cnvz_q;
  assign bus.Busy = state_q == SHIFT;
  assign bus.Done = done_q;
endmodule
